ahb_burst_addr_gen: RTL
=======================

Name: ahb_burst_addr_gen

Overview:
- Manager-side AHB address-phase sequencer, directly upstream of the bus.
- Accepts one burst command: start address, burst type, size, direction, and length for INCR.
- Drives HTRANS/HADDR/HBURST/HSIZE/HWRITE beat by beat, honouring HREADY and HRESP.
- Encodings match the global package enums: ahbBurstEnum, ahbTransferEnum, ahbHsizeEnum, ahbRespEnum.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width. Sets the maximum legal HSIZE = log2(DATA_WIDTH/8).

Ports:
- hclk  in  1  bus clock.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  generator idle, command accepted when cmd_valid=1.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_burst  in  3  ahbBurstEnum.
- cmd_size  in  3  ahbHsizeEnum.
- cmd_write  in  1  1=write.
- cmd_len  in  8  INCR only: beats-1 (1..256 beats). Ignored for other bursts.
- htrans  out  2  ahbTransferEnum.
- haddr  out  ADDR_WIDTH  transfer address.
- hburst  out  3  burst type.
- hsize  out  3  transfer size.
- hwrite  out  1  direction.
- hready  in  1  combined transfer completion.
- hresp  in  1  0=OKAY, 1=ERROR.
- done  out  1  one-cycle pulse: burst completed.
- err  out  1  one-cycle pulse: command rejected or burst aborted.

Behaviour:
- Reset (async, hresetn=0):
  - htrans=IDLE, haddr=0, hburst=SINGLE, hsize=BYTE, hwrite=0.
  - cmd_ready=0, done=0, err=0, FSM=IDLE.
  - cmd_ready rises the first hclk edge after reset release.
  - Reset mid-burst: outputs return to reset values immediately; the burst is discarded with no done or err.
- FSM states:
  - IDLE: cmd_ready=1.
  - ADDR: a beat is on the bus.
  - ERRW: waiting out the second error cycle.
- Command accept:
  - Accepted at edge k when cmd_valid & cmd_ready.
  - Cycle k+1: htrans=NONSEQ, haddr=cmd_addr, hburst/hsize/hwrite latched. cmd_ready=0.
- Legality check at accept. The command is rejected if any of the following holds:
  - cmd_size > log2(DATA_WIDTH/8).
  - cmd_addr not aligned to 2^cmd_size.
  - Fixed-length INCRx whose span crosses a 1KB boundary.
- Rejected command: err pulses at k+1, htrans stays IDLE, cmd_ready stays 1.
- Beat count: SINGLE=1, INCR=cmd_len+1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16. Internal down-counter is 9 bits.
- Advance rule:
  - Outputs hold while hready=0.
  - On hready=1 with a beat remaining: haddr = next address, htrans=SEQ.
  - On hready=1 on the last beat: htrans=IDLE next cycle, done pulses next cycle, FSM→IDLE.
- Next address:
  - inc = 1<<hsize.
  - INCR*: haddr+inc, modulo 2^ADDR_WIDTH.
  - WRAPn: bound = n*inc; next = (haddr & ~(bound-1)) | ((haddr+inc) & (bound-1)).
- Undefined-length INCR at 1KB crossing: when the next address has bits[9:0]==0, that beat is driven NONSEQ instead of SEQ. hburst stays INCR.
- ERROR response:
  - hresp=1 & hready=0 in ADDR: next cycle htrans=IDLE, FSM→ERRW, remaining beats cancelled.
  - In ERRW, when hready=1: err pulses, FSM→IDLE.
  - done is not asserted for an aborted burst.
- Minimum one IDLE cycle between consecutive bursts.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro: AHB_BUSY_INSERT_EN.
- Defined:
  - Adds input busy_req (1 bit).
  - When busy_req=1 at an hready=1 edge and at least one beat remains, the next cycle drives htrans=BUSY with haddr already at the next beat address.
  - BUSY repeats while busy_req=1. The counter does not decrement during BUSY.
  - On busy_req=0, that beat is driven SEQ.
  - Never inserted before the first beat or after the last beat.
- Undefined: port absent; htrans never equals BUSY.

Test Plan:
- WRAP4, WORD, addr 0x38, hready=1 → haddr 0x38/0x3C/0x30/0x34, htrans NONSEQ,SEQ,SEQ,SEQ then IDLE; done 1 cycle.
- INCR8, HALFWORD, 0x100, hready=0 for 2 cycles during beat 3 (0x104) → haddr/htrans held 3 cycles; final beat 0x10E; done.
- INCR, cmd_len=3, WORD, 0x3F8 → 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- INCR4, WORD, 0x200; hresp=1/hready=0 on beat 2, then hresp=1/hready=1 → htrans=IDLE the cycle after the first error cycle; err pulse; no done; cmd_ready=1 afterwards.
- Illegal commands → err pulse, htrans remains IDLE, no bus activity:
  - INCR16, WORD, 0x3F0 (crosses 1KB).
  - DOUBLEWORD with DATA_WIDTH=32.
  - WORD at 0x102.
- hresetn low mid-INCR16 → htrans=IDLE and haddr=0 asynchronously; cmd_ready=1 one edge after release; new SINGLE runs normally.

Source files
------------

// File: rtl/ahb_burst_addr_gen.sv
// AHB manager address-phase sequencer: takes one burst command and drives HTRANS/HADDR beat by beat.
// Optional BUSY insertion (busy_req input) is enabled with `define AHB_BUSY_INSERT_EN.
module ahb_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_burst,
   input  logic [2:0]            cmd_size,
   input  logic                  cmd_write,
   input  logic [7:0]            cmd_len,
   output logic [1:0]            htrans,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [2:0]            hburst,
   output logic [2:0]            hsize,
   output logic                  hwrite,
   input  logic                  hready,
   input  logic                  hresp,
`ifdef AHB_BUSY_INSERT_EN
   input  logic                  busy_req,
`endif
   output logic                  done,
   output logic                  err
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
`ifdef AHB_BUSY_INSERT_EN
   localparam logic [1:0] TR_BUSY   = 2'd1;
`endif
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [2:0] BU_SINGLE = 3'd0;
   localparam logic [2:0] BU_INCR   = 3'd1;
   localparam logic [2:0] BU_WRAP4  = 3'd2;
   localparam logic [2:0] BU_INCR4  = 3'd3;
   localparam logic [2:0] BU_WRAP8  = 3'd4;
   localparam logic [2:0] BU_INCR8  = 3'd5;
   localparam logic [2:0] BU_WRAP16 = 3'd6;
   localparam logic [2:0] BU_INCR16 = 3'd7;

   localparam logic [2:0] SZ_BYTE   = 3'd0;
   localparam logic [2:0] SIZE_MAX  = 3'($clog2(DATA_WIDTH / 8));

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_ERRW = 2'd2;

   logic [1:0]            state;
   logic [8:0]            cnt;          // beats left, including the one on haddr
   logic [ADDR_WIDTH-1:0] cmd_inc;
   logic [8:0]            cmd_beats;
   logic [31:0]           cmd_end_off;
   logic                  cmd_bad;
   logic [ADDR_WIDTH-1:0] inc, inc_addr, wrap_mask, next_addr;
   logic                  cross_next;

   // Command legality: size, alignment, and 1KB containment for fixed-length INCRx.
   always_comb begin
      cmd_inc = ADDR_WIDTH'(1) << cmd_size;
      case (cmd_burst)
         BU_INCR:            cmd_beats = {1'b0, cmd_len} + 9'd1;
         BU_WRAP4, BU_INCR4:   cmd_beats = 9'd4;
         BU_WRAP8, BU_INCR8:   cmd_beats = 9'd8;
         BU_WRAP16, BU_INCR16: cmd_beats = 9'd16;
         default:            cmd_beats = 9'd1;
      endcase
      cmd_end_off = 32'(cmd_addr[9:0]) + (32'(cmd_beats) << cmd_size) - 32'd1;
      cmd_bad = (cmd_size > SIZE_MAX)
             || (|(cmd_addr & (cmd_inc - ADDR_WIDTH'(1))))
             || ((cmd_burst inside {BU_INCR4, BU_INCR8, BU_INCR16}) && (cmd_end_off > 32'd1023));
   end

   always_comb begin
      inc      = ADDR_WIDTH'(1) << hsize;
      inc_addr = haddr + inc;
      case (hburst)
         BU_WRAP4:  wrap_mask = (inc << 2) - ADDR_WIDTH'(1);
         BU_WRAP8:  wrap_mask = (inc << 3) - ADDR_WIDTH'(1);
         BU_WRAP16: wrap_mask = (inc << 4) - ADDR_WIDTH'(1);
         default:   wrap_mask = '0;
      endcase
      next_addr  = (wrap_mask == '0) ? inc_addr : ((haddr & ~wrap_mask) | (inc_addr & wrap_mask));
      // Undefined-length INCR restarts as NONSEQ on a 1KB boundary.
      cross_next = (hburst == BU_INCR) && (next_addr[9:0] == 10'd0);
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b0;
         htrans    <= TR_IDLE;
         haddr     <= '0;
         hburst    <= BU_SINGLE;
         hsize     <= SZ_BYTE;
         hwrite    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  if (cmd_bad) begin
                     err <= 1'b1;
                  end else begin
                     cmd_ready <= 1'b0;
                     state     <= ST_ADDR;
                     htrans    <= TR_NONSEQ;
                     haddr     <= cmd_addr;
                     hburst    <= cmd_burst;
                     hsize     <= cmd_size;
                     hwrite    <= cmd_write;
                     cnt       <= cmd_beats;
                  end
               end
            end
            ST_ADDR: begin
               if (hresp && !hready) begin
                  htrans <= TR_IDLE;
                  state  <= ST_ERRW;
               end else if (hready) begin
`ifdef AHB_BUSY_INSERT_EN
                  // haddr already holds the pending beat; leave BUSY without counting.
                  if (htrans == TR_BUSY) begin
                     if (busy_req)
                        htrans <= TR_BUSY;
                     else
                        htrans <= ((hburst == BU_INCR) && (haddr[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
                  end else
`endif
                  if (cnt == 9'd1) begin
                     htrans    <= TR_IDLE;
                     done      <= 1'b1;
                     cmd_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     haddr <= next_addr;
                     cnt   <= cnt - 9'd1;
`ifdef AHB_BUSY_INSERT_EN
                     if (busy_req)
                        htrans <= TR_BUSY;
                     else
`endif
                     htrans <= cross_next ? TR_NONSEQ : TR_SEQ;
                  end
               end
            end
            ST_ERRW: begin
               if (hready) begin
                  err       <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
